// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the 128-bit cipher state and walks it through
// the initial AddRoundKey and NR rounds. SubBytes runs on an external, clocked
// S-box block and MixColumns on an external combinational block. ShiftRows is
// plain wiring. The external key schedule supplies round_key for round_idx.
module aes_round_ctrl #(
  parameter int unsigned NR       = 10,  // number of rounds, 1..14
  parameter int unsigned SBOX_LAT = 1    // sub_byte latency in cycles, 1..4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] block_in,
  output logic         ready,
  output logic         busy,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  output logic [127:0] mc_in,
  input  logic [127:0] mc_out,
  output logic [127:0] block_out,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    ROUND = 2'd2
  } state_t;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [2:0] LAT_LAST = 3'(SBOX_LAT - 1);

  state_t       state_q;
  state_t       state_d;
  logic [127:0] state_reg;
  logic [127:0] state_reg_d;
  logic [3:0]   round_idx_d;
  logic [2:0]   lat_cnt;
  logic [2:0]   lat_cnt_d;
  logic [127:0] block_out_d;
  logic         done_d;

  // ShiftRows: output byte k takes input byte (k + 4*(k mod 4)) mod 16,
  // i.e. row r of the column-major state rotates left by r columns.
  for (genvar k = 0; k < 16; k++) begin : g_shift_rows
    assign mc_in[127-8*k -: 8] = sb_out[127-8*((k + 4*(k % 4)) % 16) -: 8];
  end

  // The S-box input follows the state register in every state; it only
  // matters while in SUB, where the register is not written.
  assign sb_in = state_reg;
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);

  // FSM state and all datapath registers, async clear on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      state_reg <= '0;
      round_idx <= '0;
      lat_cnt   <= '0;
      block_out <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      state_reg <= state_reg_d;
      round_idx <= round_idx_d;
      lat_cnt   <= lat_cnt_d;
      block_out <= block_out_d;
      done      <= done_d;
    end
  end

  // Next-state and next-register values for the round sequencing.
  always_comb begin
    state_d     = state_q;
    state_reg_d = state_reg;
    round_idx_d = round_idx;
    lat_cnt_d   = lat_cnt;
    block_out_d = block_out;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Initial AddRoundKey with round_key[0] (round_idx is 0 in IDLE).
          state_reg_d = block_in ^ round_key;
          round_idx_d = 4'd1;
          lat_cnt_d   = '0;
          state_d     = SUB;
        end
      end

      SUB: begin
        if (lat_cnt == LAT_LAST) begin
          lat_cnt_d = '0;
          state_d   = ROUND;
        end else begin
          lat_cnt_d = lat_cnt + 3'd1;
        end
      end

      ROUND: begin
        if (round_idx == NR_IDX) begin
          // Final round skips MixColumns.
          block_out_d = mc_in ^ round_key;
          done_d      = 1'b1;
          round_idx_d = '0;
          state_d     = IDLE;
        end else begin
          state_reg_d = mc_out ^ round_key;
          round_idx_d = round_idx + 4'd1;
          state_d     = SUB;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (S-box latency 1 and 2), each with
// behavioural S-box pipeline, MixColumns and key schedule models, checked
// against FIPS-197 vectors and a plain AES-128 reference on random blocks.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]   sbox [256];
  logic [127:0] rk_tab [2][16];

  logic         start_v  [2];
  logic [127:0] blk_v    [2];
  logic         ready_v  [2];
  logic         busy_v   [2];
  logic         done_v   [2];
  logic [3:0]   idx_v    [2];
  logic [127:0] rkey_v   [2];
  logic [127:0] sb_in_v  [2];
  logic [127:0] sb_out_v [2];
  logic [127:0] mc_in_v  [2];
  logic [127:0] mc_out_v [2];
  logic [127:0] bout_v   [2];

  int n_checks = 0;
  int n_fail   = 0;

  localparam int SR_MAP [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[127-8*SR_MAP[k] -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] key_round(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key_round(key, 0);
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < 10) s = mix_columns(s);
      s = s ^ key_round(key, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [127:0] p0;
    logic [127:0] p1;

    aes_round_ctrl #(.NR(10), .SBOX_LAT(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .block_in  (blk_v[g]),
      .ready     (ready_v[g]),
      .busy      (busy_v[g]),
      .round_idx (idx_v[g]),
      .round_key (rkey_v[g]),
      .sb_in     (sb_in_v[g]),
      .sb_out    (sb_out_v[g]),
      .mc_in     (mc_in_v[g]),
      .mc_out    (mc_out_v[g]),
      .block_out (bout_v[g]),
      .done      (done_v[g])
    );

    assign rkey_v[g]   = rk_tab[g][idx_v[g]];
    assign mc_out_v[g] = mix_columns(mc_in_v[g]);

    // Clocked S-box with g+1 register stages.
    always_ff @(posedge clk) begin
      p0 <= sub_bytes(sb_in_v[g]);
      p1 <= p0;
    end
    assign sb_out_v[g] = (g == 0) ? p0 : p1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input int d, input logic [127:0] key);
    for (int r = 0; r < 16; r++) rk_tab[d][r] = (r <= 10) ? key_round(key, r) : '0;
  endtask

  // Encrypt one block on instance d starting in the current cycle; returns in
  // the done cycle. prev is the block_out value that must hold while busy.
  task automatic enc(input int d, input logic [127:0] pt, input logic [127:0] key,
                     input logic [127:0] prev, input bit poke, input logic [127:0] exp);
    int t;
    int lat;
    logic [127:0] sb_hold;
    lat = d + 1;
    sb_hold = '0;
    check("pre_ready", 128'(ready_v[d]), 128'(1));
    load_keys(d, key);
    blk_v[d] = pt;
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    blk_v[d] = rand128();
    t = 0;
    while (done_v[d] !== 1'b1 && t < 200) begin
      check("busy", 128'(busy_v[d]), 128'(1));
      check("ready", 128'(ready_v[d]), 128'(0));
      check("round_idx", 128'(idx_v[d]), 128'(1 + t / (lat + 1)));
      check("hold_out", bout_v[d], prev);
      if (t % (lat + 1) == 0) sb_hold = sb_in_v[d];
      else if (t % (lat + 1) < lat) check("sb_stable", sb_in_v[d], sb_hold);
      start_v[d] = poke && (t == 4 || t == 11);
      if (poke) blk_v[d] = rand128();
      step();
      t++;
    end
    start_v[d] = 1'b0;
    check("latency", 128'(t), 128'(10 * (lat + 1)));
    check("done_ready", 128'(ready_v[d]), 128'(1));
    check("done_busy", 128'(busy_v[d]), 128'(0));
    check("done_idx", 128'(idx_v[d]), 128'(0));
    check("block_out", bout_v[d], exp);
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] last;
    logic [127:0] k;
    logic [127:0] p;
    bit seen;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] r;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int i = 0; i < 4; i++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[x] = s ^ 8'h63;
    end

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      blk_v[d] = '0;
      for (int r = 0; r < 16; r++) rk_tab[d][r] = '0;
    end
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 128'(ready_v[d]), 128'(1));
      check("rst_busy", 128'(busy_v[d]), 128'(0));
      check("rst_done", 128'(done_v[d]), 128'(0));
      check("rst_idx", 128'(idx_v[d]), 128'(0));
      check("rst_out", bout_v[d], 128'(0));
    end
    rst = 1'b0;
    step();

    // FIPS App. B, then App. C.1 accepted in the done cycle.
    enc(0, PT_B, KEY_B, '0, 1'b0, CT_B);
    enc(0, PT_C, KEY_C, CT_B, 1'b0, CT_C);
    step();
    check("done_pulse", 128'(done_v[0]), 128'(0));
    check("out_held", bout_v[0], CT_C);
    last = CT_C;

    // Start pulses while busy must be ignored.
    k = rand128();
    p = rand128();
    enc(0, p, k, last, 1'b1, ref_encrypt(p, k));
    last = ref_encrypt(p, k);

    // Random blocks with random idle gaps.
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 3)) step();
      k = rand128();
      p = rand128();
      enc(0, p, k, last, 1'b0, ref_encrypt(p, k));
      last = ref_encrypt(p, k);
    end

    // Asynchronous reset in the middle of a block.
    step();
    load_keys(0, KEY_B);
    blk_v[0] = PT_B;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (8) step();
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 128'(ready_v[0]), 128'(1));
    check("arst_busy", 128'(busy_v[0]), 128'(0));
    check("arst_idx", 128'(idx_v[0]), 128'(0));
    check("arst_out", bout_v[0], 128'(0));
    check("arst_done", 128'(done_v[0]), 128'(0));
    step();
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (done_v[0] === 1'b1) seen = 1'b1;
    end
    check("no_done_after_abort", 128'(seen), 128'(0));
    enc(0, PT_B, KEY_B, '0, 1'b0, CT_B);

    // Two-stage S-box instance.
    step();
    enc(1, PT_B, KEY_B, '0, 1'b0, CT_B);
    last = CT_B;
    for (int n = 0; n < 2; n++) begin
      k = rand128();
      p = rand128();
      enc(1, p, k, last, 1'b0, ref_encrypt(p, k));
      last = ref_encrypt(p, k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
